// File: rtl/bp_fe_fetch_seq.sv
// Fetch sequencer for the I$ wrapper: streams sequential fetches after a redirect,
// emits the identity-translated ptag one cycle later and buffers returned instructions.
module bp_fe_fetch_seq #(
  parameter int vaddr_width_p       = 39,
  parameter int ptag_width_p        = 28,
  parameter int page_offset_width_p = 12,
  parameter int instr_width_p       = 32,
  parameter int max_outstanding_p   = 4,
  parameter int count_width_p       = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,

  input  logic                     redirect_v_i,
  input  logic [vaddr_width_p-1:0] redirect_vaddr_i,
  input  logic [count_width_p-1:0] redirect_count_i,
  input  logic                     redirect_uncached_i,
  output logic                     redirect_ready_o,

  output logic [vaddr_width_p-1:0] vaddr_o,
  output logic                     vaddr_v_o,
  input  logic                     vaddr_ready_i,

  output logic [ptag_width_p-1:0]  ptag_o,
  output logic                     ptag_v_o,
  output logic                     uncached_o,

  input  logic [instr_width_p-1:0] data_i,
  input  logic                     data_v_i,

  output logic [instr_width_p-1:0] instr_o,
  output logic [vaddr_width_p-1:0] pc_o,
  output logic                     instr_v_o,
  input  logic                     instr_yumi_i,

  output logic                     done_o,
  output logic                     error_o
);

  localparam int PTR_W     = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int CNT_W     = $clog2(max_outstanding_p) + 1;
  localparam int TAG_SRC_W = vaddr_width_p - page_offset_width_p;
  localparam logic [CNT_W-1:0] MAX_CRED = CNT_W'(max_outstanding_p);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e                   state_q, state_d;
  logic [vaddr_width_p-1:0] pc_q, pc_d;
  logic [count_width_p-1:0] remaining_q, remaining_d;
  logic                     uncached_run_q, uncached_run_d;
  logic [CNT_W-1:0]         credits_q, credits_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic                     ptag_v_q, ptag_v_d;
  logic [ptag_width_p-1:0]  ptag_q, ptag_d;
  logic                     uncached_q, uncached_d;

  logic [PTR_W-1:0]         pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
  logic [CNT_W-1:0]         pcq_cnt_q, pcq_cnt_d;
  logic [PTR_W-1:0]         rb_wr_q, rb_wr_d, rb_rd_q, rb_rd_d;
  logic [CNT_W-1:0]         rb_cnt_q, rb_cnt_d;

  logic [vaddr_width_p-1:0] pcq_mem      [max_outstanding_p];
  logic [vaddr_width_p-1:0] rb_pc_mem    [max_outstanding_p];
  logic [instr_width_p-1:0] rb_instr_mem [max_outstanding_p];

  logic                     fetch_hs;
  logic                     pcq_push, pcq_pop, rb_push, rb_pop;
  logic [ptag_width_p-1:0]  issue_tag;

  // Issue gating uses registered credits only, so vaddr_v_o never depends on ready.
  assign vaddr_v_o = (state_q == FETCH) && (remaining_q != '0) && (credits_q < MAX_CRED);
  assign fetch_hs  = vaddr_v_o & vaddr_ready_i;
  assign pcq_push  = fetch_hs;
  assign pcq_pop   = data_v_i && (pcq_cnt_q != '0);
  assign rb_push   = pcq_pop;
  assign rb_pop    = instr_yumi_i && (rb_cnt_q != '0);

  generate
    if (TAG_SRC_W >= ptag_width_p) begin : g_tag_trunc
      assign issue_tag = pc_q[page_offset_width_p +: ptag_width_p];
    end else begin : g_tag_ext
      assign issue_tag = {{(ptag_width_p-TAG_SRC_W){1'b0}},
                          pc_q[vaddr_width_p-1:page_offset_width_p]};
    end
  endgenerate

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    remaining_d    = remaining_q;
    uncached_run_d = uncached_run_q;
    done_d         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect_v_i) begin
          pc_d           = redirect_vaddr_i & ~vaddr_width_p'(3);
          remaining_d    = redirect_count_i;
          uncached_run_d = redirect_uncached_i;
          if (redirect_count_i == '0) done_d = 1'b1;
          else                        state_d = FETCH;
        end
      end
      FETCH: begin
        if (fetch_hs) begin
          pc_d        = pc_q + vaddr_width_p'(4);
          remaining_d = remaining_q - count_width_p'(1);
          if (remaining_q == count_width_p'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (credits_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptag_v_d   = fetch_hs;
    ptag_d     = fetch_hs ? issue_tag : '0;
    uncached_d = fetch_hs & uncached_run_q;
    credits_d  = credits_q + CNT_W'(fetch_hs) - CNT_W'(rb_pop);
    error_d    = error_q | (data_v_i & (pcq_cnt_q == '0));

    pcq_wr_d   = pcq_push ? pcq_wr_q + PTR_W'(1) : pcq_wr_q;
    pcq_rd_d   = pcq_pop  ? pcq_rd_q + PTR_W'(1) : pcq_rd_q;
    pcq_cnt_d  = pcq_cnt_q + CNT_W'(pcq_push) - CNT_W'(pcq_pop);

    rb_wr_d    = rb_push ? rb_wr_q + PTR_W'(1) : rb_wr_q;
    rb_rd_d    = rb_pop  ? rb_rd_q + PTR_W'(1) : rb_rd_q;
    rb_cnt_d   = rb_cnt_q + CNT_W'(rb_push) - CNT_W'(rb_pop);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q        <= IDLE;
      pc_q           <= '0;
      remaining_q    <= '0;
      uncached_run_q <= 1'b0;
      credits_q      <= '0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      ptag_v_q       <= 1'b0;
      ptag_q         <= '0;
      uncached_q     <= 1'b0;
      pcq_wr_q       <= '0;
      pcq_rd_q       <= '0;
      pcq_cnt_q      <= '0;
      rb_wr_q        <= '0;
      rb_rd_q        <= '0;
      rb_cnt_q       <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      remaining_q    <= remaining_d;
      uncached_run_q <= uncached_run_d;
      credits_q      <= credits_d;
      done_q         <= done_d;
      error_q        <= error_d;
      ptag_v_q       <= ptag_v_d;
      ptag_q         <= ptag_d;
      uncached_q     <= uncached_d;
      pcq_wr_q       <= pcq_wr_d;
      pcq_rd_q       <= pcq_rd_d;
      pcq_cnt_q      <= pcq_cnt_d;
      rb_wr_q        <= rb_wr_d;
      rb_rd_q        <= rb_rd_d;
      rb_cnt_q       <= rb_cnt_d;
    end
  end

  // Storage arrays carry no reset; empty entries are masked on the outputs.
  always_ff @(posedge clk_i) begin
    if (pcq_push) pcq_mem[pcq_wr_q] <= pc_q;
    if (rb_push) begin
      rb_pc_mem[rb_wr_q]    <= pcq_mem[pcq_rd_q];
      rb_instr_mem[rb_wr_q] <= data_i;
    end
  end

  assign redirect_ready_o = (state_q == IDLE);
  assign vaddr_o          = pc_q;
  assign ptag_v_o         = ptag_v_q;
  assign ptag_o           = ptag_q;
  assign uncached_o       = uncached_q;
  assign instr_v_o        = (rb_cnt_q != '0);
  assign instr_o          = instr_v_o ? rb_instr_mem[rb_rd_q] : '0;
  assign pc_o             = instr_v_o ? rb_pc_mem[rb_rd_q] : '0;
  assign done_o           = done_q;
  assign error_o          = error_q;

endmodule

// File: tb/tb_bp_fe_fetch_seq.sv
// Bench for bp_fe_fetch_seq: table of redirect runs checked through a PC/instruction
// scoreboard and a ptag scoreboard, plus hand sequences for count-0, error and reset.
module tb_bp_fe_fetch_seq;

  localparam int MAXO = 4;

  logic        clk;
  logic        reset_n_i;
  logic        redirect_v_i;
  logic [38:0] redirect_vaddr_i;
  logic [15:0] redirect_count_i;
  logic        redirect_uncached_i;
  logic        redirect_ready_o;
  logic [38:0] vaddr_o;
  logic        vaddr_v_o;
  logic        vaddr_ready_i;
  logic [27:0] ptag_o;
  logic        ptag_v_o;
  logic        uncached_o;
  logic [31:0] data_i;
  logic        data_v_i;
  logic [31:0] instr_o;
  logic [38:0] pc_o;
  logic        instr_v_o;
  logic        instr_yumi_i;
  logic        done_o;
  logic        error_o;

  bp_fe_fetch_seq dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .redirect_v_i(redirect_v_i), .redirect_vaddr_i(redirect_vaddr_i),
    .redirect_count_i(redirect_count_i), .redirect_uncached_i(redirect_uncached_i),
    .redirect_ready_o(redirect_ready_o),
    .vaddr_o(vaddr_o), .vaddr_v_o(vaddr_v_o), .vaddr_ready_i(vaddr_ready_i),
    .ptag_o(ptag_o), .ptag_v_o(ptag_v_o), .uncached_o(uncached_o),
    .data_i(data_i), .data_v_i(data_v_i),
    .instr_o(instr_o), .pc_o(pc_o), .instr_v_o(instr_v_o), .instr_yumi_i(instr_yumi_i),
    .done_o(done_o), .error_o(error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [38:0] vaddr;
    int          count;
    bit          uc;
    int          stall;
    bit          rnd;
    int          exp_stall_hs;
    logic [38:0] exp_last_pc;
    logic [27:0] exp_last_ptag;
  } run_t;

  typedef struct {
    logic [38:0] pc;
    logic [31:0] instr;
  } ret_t;

  int          n_chk = 0;
  int          n_pass = 0;
  ret_t        exp_q[$];
  logic [27:0] exp_tag_q[$];
  logic [38:0] ic_q[$];
  bit          hs_prev = 1'b0;
  bit          cur_uc = 1'b0;
  bit          rnd = 1'b0;
  bit          yumi_ok = 1'b1;
  bit          spurious = 1'b0;
  int          hs_cnt = 0;
  int          done_cnt = 0;
  int          out_cnt = 0;
  logic [38:0] last_pc = '0;
  logic [27:0] last_tag = '0;
  run_t        tbl[5];

  function automatic logic [31:0] imem(input logic [38:0] a);
    return a[31:0] ^ 32'h5A5A_C3C3 ^ {25'd0, a[38:32]};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s got=event exp=none", name);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_ctrl"}, 128'({redirect_ready_o, vaddr_v_o, ptag_v_o, uncached_o,
                               instr_v_o, done_o, error_o}), 128'(7'b1000000));
    chk({name, "_addr"}, 128'({vaddr_o, ptag_o}), 128'(0));
    chk({name, "_data"}, 128'({instr_o, pc_o}), 128'(0));
  endtask

  // One cycle: check outputs at the falling edge, then drive next inputs.
  task automatic tick();
    ret_t        e;
    logic [27:0] t;
    logic [38:0] a;
    @(negedge clk);
    redirect_v_i = 1'b0;
    if (hs_prev) begin
      t = '0;
      if (exp_tag_q.size() == 0) fail("ptag_extra");
      else t = exp_tag_q.pop_front();
      chk("ptag", 128'({ptag_v_o, uncached_o, ptag_o}), 128'({1'b1, cur_uc, t}));
      last_tag = ptag_o;
    end else begin
      chk("ptag_idle", 128'({ptag_v_o, uncached_o, ptag_o}), 128'(0));
    end
    if (done_o) done_cnt++;

    data_v_i = 1'b0;
    data_i   = '0;
    if (spurious) begin
      data_v_i = 1'b1;
      data_i   = 32'hDEAD_BEEF;
      spurious = 1'b0;
    end else if (ic_q.size() > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
      a        = ic_q.pop_front();
      data_v_i = 1'b1;
      data_i   = imem(a);
    end

    instr_yumi_i = 1'b0;
    if (instr_v_o && yumi_ok && (!rnd || $urandom_range(0, 1) == 1)) begin
      instr_yumi_i = 1'b1;
      if (exp_q.size() == 0) fail("ret_extra");
      else begin
        e = exp_q.pop_front();
        chk("ret", 128'({pc_o, instr_o}), 128'({e.pc, e.instr}));
      end
      last_pc = pc_o;
    end

    if (out_cnt == MAXO) chk("credit_stall", 128'(vaddr_v_o), 128'(0));

    vaddr_ready_i = !rnd || ($urandom_range(0, 3) != 0);
    hs_prev = vaddr_v_o & vaddr_ready_i;
    if (hs_prev) begin
      ic_q.push_back(vaddr_o);
      hs_cnt++;
    end
    out_cnt = out_cnt + int'(hs_prev) - int'(instr_yumi_i);
  endtask

  task automatic start_run(input run_t r);
    logic [38:0] p;
    ret_t        e;
    chk("ready_before", 128'({redirect_ready_o, instr_v_o}), 128'(2'b10));
    p = r.vaddr & ~39'h3;
    for (int i = 0; i < r.count; i++) begin
      e.pc    = p;
      e.instr = imem(p);
      exp_q.push_back(e);
      exp_tag_q.push_back({1'b0, p[38:12]});
      p = p + 39'd4;
    end
    cur_uc   = r.uc;
    rnd      = r.rnd;
    hs_cnt   = 0;
    done_cnt = 0;
    redirect_v_i        = 1'b1;
    redirect_vaddr_i    = r.vaddr;
    redirect_count_i    = 16'(r.count);
    redirect_uncached_i = r.uc;
  endtask

  task automatic finish_run(input run_t r);
    for (int t = 0; t < 400 && done_cnt == 0; t++) begin
      yumi_ok = (t >= r.stall);
      tick();
      if (r.stall > 0 && t == r.stall - 1)
        chk("stall_hs", 128'(hs_cnt), 128'(r.exp_stall_hs));
    end
    if (done_cnt == 0) fail("run_timeout");
    repeat (3) tick();
    chk("done_once", 128'(done_cnt), 128'(1));
    chk("drained", 128'({exp_q.size(), exp_tag_q.size()}), 128'(0));
    chk("last_pc", 128'(last_pc), 128'(r.exp_last_pc));
    chk("last_ptag", 128'(last_tag), 128'(r.exp_last_ptag));
    chk("ready_after", 128'(redirect_ready_o), 128'(1));
  endtask

  initial begin
    run_t rr;
    tbl[0] = '{39'h00_8000_0000,  8, 1'b0,  0, 1'b0, 0, 39'h00_8000_001C, 28'h0080000};
    tbl[1] = '{39'h00_8000_1000, 10, 1'b1, 12, 1'b0, 4, 39'h00_8000_1024, 28'h0080001};
    tbl[2] = '{39'h00_8000_0FFC,  2, 1'b0,  0, 1'b0, 0, 39'h00_8000_1000, 28'h0080001};
    tbl[3] = '{39'h7F_FFFF_FFFC,  2, 1'b1,  0, 1'b0, 0, 39'h00_0000_0000, 28'h0000000};
    tbl[4] = '{39'h00_1234_5677,  5, 1'b1,  0, 1'b1, 0, 39'h00_1234_5684, 28'h0012345};

    reset_n_i = 1'b0;
    redirect_v_i = 1'b0; redirect_vaddr_i = '0; redirect_count_i = '0;
    redirect_uncached_i = 1'b0; vaddr_ready_i = 1'b0;
    data_i = '0; data_v_i = 1'b0; instr_yumi_i = 1'b0;
    #2;
    check_reset("rst_init");
    repeat (2) @(negedge clk);
    reset_n_i = 1'b1;

    for (int i = 0; i < 5; i++) begin
      start_run(tbl[i]);
      finish_run(tbl[i]);
    end

    // Zero-length run: no fetch, single done pulse the next cycle.
    rnd = 1'b0;
    done_cnt = 0;
    chk("zc_ready", 128'(redirect_ready_o), 128'(1));
    redirect_v_i = 1'b1; redirect_vaddr_i = 39'h00_4000_0000;
    redirect_count_i = '0; redirect_uncached_i = 1'b0;
    tick();
    chk("zc_pulse", 128'({done_o, vaddr_v_o, redirect_ready_o}), 128'(3'b101));
    tick();
    chk("zc_after", 128'({done_o, vaddr_v_o, redirect_ready_o}), 128'(3'b001));
    repeat (2) tick();
    chk("zc_count", 128'(done_cnt), 128'(1));

    // Spurious return with nothing outstanding.
    chk("err_pre", 128'(error_o), 128'(0));
    spurious = 1'b1;
    tick();
    tick();
    chk("err_set", 128'({error_o, instr_v_o}), 128'(2'b10));
    repeat (3) tick();
    chk("err_sticky", 128'({error_o, instr_v_o}), 128'(2'b10));

    // Reset in the middle of a run with three fetches outstanding.
    rr = '{39'h00_4000_0000, 10, 1'b1, 0, 1'b0, 0, 39'h0, 28'h0};
    start_run(rr);
    yumi_ok = 1'b0;
    for (int t = 0; t < 20 && hs_cnt < 3; t++) tick();
    if (hs_cnt < 3) fail("mid_hs_timeout");
    @(posedge clk);
    #1;
    reset_n_i = 1'b0;
    #1;
    check_reset("rst_mid");
    ic_q.delete(); exp_q.delete(); exp_tag_q.delete();
    hs_prev = 1'b0; out_cnt = 0;
    data_v_i = 1'b0; data_i = '0; instr_yumi_i = 1'b0; redirect_v_i = 1'b0;
    yumi_ok = 1'b1;
    @(negedge clk);
    reset_n_i = 1'b1;
    start_run(tbl[0]);
    finish_run(tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
